// File: rtl/multiplier_control.sv
// rtl/multiplier_control.sv - sequencing FSM for the signed add-shift multiplier
module multiplier_control #(
  parameter int N = 8
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Run,
  input  logic ClearA_LoadB,
  input  logic M,
  output logic Clr_XA,
  output logic Ld_B,
  output logic Ld_XA,
  output logic Sub,
  output logic Shift_En,
  output logic Busy,
  output logic Done
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [2:0] {IDLE, START, ADD, SHIFT, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE:  if (Run) state <= START;
        START: begin
          cnt   <= '0;
          state <= ADD;
        end
        ADD:   state <= SHIFT;
        SHIFT: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt   <= cnt + 1'b1;
            state <= ADD;
          end
        end
        DONE:  if (!Run) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Decode from registered state; Ld_XA/Sub follow M and IDLE follows the requests.
  always_comb begin
    Clr_XA   = 1'b0;
    Ld_B     = 1'b0;
    Ld_XA    = 1'b0;
    Sub      = 1'b0;
    Shift_En = 1'b0;
    Busy     = 1'b0;
    Done     = 1'b0;
    case (state)
      IDLE: begin
        Clr_XA = ClearA_LoadB & ~Run;
        Ld_B   = ClearA_LoadB & ~Run;
      end
      START: begin
        Clr_XA = 1'b1;
        Busy   = 1'b1;
      end
      ADD: begin
        Ld_XA = M;
        Sub   = M & (cnt == LAST);
        Busy  = 1'b1;
      end
      SHIFT: begin
        Shift_En = 1'b1;
        Busy     = 1'b1;
      end
      DONE: Done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multiplier_control.sv
// tb/tb_multiplier_control.sv - randomized self-checking bench for multiplier_control
module tb_multiplier_control;

  localparam int N = 8;

  logic Clk = 1'b0;
  logic Reset, Run, ClearA_LoadB, M;
  logic Clr_XA, Ld_B, Ld_XA, Sub, Shift_En, Busy, Done;

  multiplier_control #(.N(N)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .M(M),
    .Clr_XA(Clr_XA), .Ld_B(Ld_B), .Ld_XA(Ld_XA), .Sub(Sub),
    .Shift_En(Shift_En), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // k = cycles since Run was accepted: 0 idle, 1..2N+1 busy, 2N+2 done
  int   k = 0;
  bit   model_ok = 0;
  logic       x_m;
  logic [7:0] a_m, b_m, s_m, sw;
  logic [6:0] o_vec;
  int   n_shift, n_ldxa, n_sub, n_busy, n_busy_rise;
  logic prev_busy = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected {Clr_XA, Ld_B, Ld_XA, Sub, Shift_En, Busy, Done} from the cycle timeline
  function automatic logic [6:0] expect_outs(input int kk, input logic run, input logic clb,
                                             input logic m);
    logic [6:0] e = '0;
    if (kk == 0) begin
      e[6] = clb & ~run;
      e[5] = clb & ~run;
    end else if (kk == 1) begin
      e[6] = 1'b1;
      e[1] = 1'b1;
    end else if (kk <= 2*N + 1 && kk % 2 == 0) begin
      e[4] = m;
      e[3] = m & (kk == 2*N);
      e[1] = 1'b1;
    end else if (kk <= 2*N + 1) begin
      e[2] = 1'b1;
      e[1] = 1'b1;
    end else begin
      e[0] = 1'b1;
    end
    return e;
  endfunction

  // mmode: 0 -> M=0, 1 -> M=1, 2 -> model B[0], 3 -> random
  task automatic step(input logic run, input logic clb, input logic rst, input int mmode);
    logic [8:0] sum;
    Run = run; ClearA_LoadB = clb; Reset = rst;
    case (mmode)
      0: M = 1'b0;
      1: M = 1'b1;
      2: M = b_m[0];
      default: M = 1'($urandom_range(0, 1));
    endcase
    #1;
    o_vec = {Clr_XA, Ld_B, Ld_XA, Sub, Shift_En, Busy, Done};
    if (model_ok) check($sformatf("outs k=%0d", k), 32'(o_vec), 32'(expect_outs(k, run, clb, M)));
    n_shift += int'(Shift_En);
    n_ldxa  += int'(Ld_XA);
    n_sub   += int'(Sub);
    n_busy  += int'(Busy);
    if (Busy && !prev_busy) n_busy_rise++;
    prev_busy = Busy;
    @(posedge Clk);
    // datapath model driven by the observed control outputs
    if (o_vec[6]) begin x_m = 1'b0; a_m = 8'h00; end
    if (o_vec[5]) b_m = sw;
    if (o_vec[4]) begin
      sum = o_vec[3] ? ({a_m[7], a_m} - {s_m[7], s_m}) : ({a_m[7], a_m} + {s_m[7], s_m});
      x_m = sum[8];
      a_m = sum[7:0];
    end
    if (o_vec[2]) begin
      b_m = {a_m[0], b_m[7:1]};
      a_m = {x_m, a_m[7:1]};
    end
    if (rst) begin
      k = 0;
      model_ok = 1;
    end else if (k == 0) begin
      if (run) k = 1;
    end else if (k <= 2*N + 1) begin
      k++;
    end else if (!run) begin
      k = 0;
    end
    @(negedge Clk);
  endtask

  task automatic clear_counts();
    n_shift = 0; n_ldxa = 0; n_sub = 0; n_busy = 0; n_busy_rise = 0;
  endtask

  // Pulse Run for one cycle, then wait (bounded) for Done; reports the Done cycle
  task automatic one_mult(input int mmode, output int done_cyc);
    done_cyc = -1;
    clear_counts();
    step(1'b1, 1'b0, 1'b0, mmode);
    for (int i = 1; i <= 40; i++) begin
      step(1'b0, 1'b0, 1'b0, mmode);
      if (o_vec[0]) begin
        done_cyc = i;
        break;
      end
    end
  endtask

  task automatic load_b(input logic [7:0] bval, input logic [7:0] sval);
    sw = bval; s_m = sval;
    step(1'b0, 1'b1, 1'b0, 2);
    step(1'b0, 1'b0, 1'b0, 2);
  endtask

  int dc;

  initial begin
    x_m = 0; a_m = 0; b_m = 0; s_m = 0; sw = 0;
    Run = 0; ClearA_LoadB = 0; M = 0; Reset = 1;
    clear_counts();
    @(negedge Clk);
    step(1'b0, 1'b0, 1'b1, 0);
    step(1'b0, 1'b0, 1'b1, 0);
    check("reset_outs", 32'(o_vec), 32'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 0);

    // load request held 3 cycles
    clear_counts();
    sw = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 0);
      check("load_clr_ldb", 32'(o_vec[6:5]), 32'h3);
    end
    step(1'b0, 1'b0, 1'b0, 0);
    check("load_busy", 32'(n_busy), 0);
    check("load_b_value", 32'(b_m), 32'h5A);

    // all-ones multiplier
    one_mult(1, dc);
    check("ones_done_cyc", 32'(dc), 32'(2*N + 2));
    check("ones_shift", 32'(n_shift), 32'(N));
    check("ones_ldxa", 32'(n_ldxa), 32'(N));
    check("ones_sub", 32'(n_sub), 1);
    check("ones_busy", 32'(n_busy), 32'(2*N + 1));
    step(1'b0, 1'b0, 1'b0, 0);

    // all-zeros multiplier
    one_mult(0, dc);
    check("zeros_done_cyc", 32'(dc), 32'(2*N + 2));
    check("zeros_shift", 32'(n_shift), 32'(N));
    check("zeros_ldxa", 32'(n_ldxa), 0);
    check("zeros_sub", 32'(n_sub), 0);
    step(1'b0, 1'b0, 1'b0, 0);

    // closed loop: 7 * -59 and -128 * -128
    load_b(8'h07, 8'hC5);
    one_mult(2, dc);
    check("prod_7x_59", 32'({a_m, b_m}), 32'hFE63);
    check("prod_7x_59_x", 32'(x_m), 1);
    step(1'b0, 1'b0, 1'b0, 2);
    load_b(8'h80, 8'h80);
    one_mult(2, dc);
    check("prod_128sq", 32'({a_m, b_m}), 32'h4000);
    check("prod_128sq_sub", 32'(n_sub), 1);
    step(1'b0, 1'b0, 1'b0, 2);

    // reset mid-multiply at cycle 7
    clear_counts();
    step(1'b1, 1'b0, 1'b0, 1);
    for (int i = 1; i < 7; i++) step(1'b0, 1'b0, 1'b0, 1);
    step(1'b0, 1'b0, 1'b1, 1);
    step(1'b0, 1'b0, 1'b1, 1);
    clear_counts();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1);
    check("abort_pulses", 32'(n_shift + n_ldxa + n_busy), 0);

    // Run and ClearA_LoadB held 40 cycles
    sw = 8'h33; b_m = 8'h00;
    clear_counts();
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0, 3);
    check("held_one_mult", 32'(n_busy_rise), 1);
    check("held_shift", 32'(n_shift), 32'(N));
    check("held_done", 32'(o_vec[0]), 1);
    check("held_no_ldb", 32'(b_m == 8'h33), 0);
    step(1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 0);

    // randomized traffic against the timeline model
    for (int i = 0; i < 3000; i++) begin
      logic r;
      r = ($urandom_range(0, 7) == 0) ? ~Run : Run;
      step(r, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 150) == 0),
           ($urandom_range(0, 1) == 0) ? 2 : 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
